cda_pipe_adder: RTL and testbench

Parametrised, pipelined carry-disregard approximate adder, the multi-block successor to the fixed 8-bit single-block adder. Operands are split into BLOCK-bit segments. In approximate mode each segment's carry-in is speculated from only the top LOOK bits of the segment below. In exact mode the carry ripples fully. The block sits between operand sources and the partial-product accumulation logic of the approximate multipliers. It adds a two-stage valid/ready pipeline, a per-result mismatch flag, and a saturating error counter for accuracy characterisation.

---
 rtl/cda_pipe_adder.sv | 115 +++++++++++
 tb/tb_cda_pipe_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cda_pipe_adder.sv
// rtl/cda_pipe_adder.sv - two-stage pipelined carry-disregard approximate adder
module cda_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 8,
    parameter int LOOK  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             approx_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   sum_o,
    output logic             mismatch_o,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] err_cnt_o
);
    localparam int NSEG = WIDTH / BLOCK;

    logic             s1_full_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             approx_q;
    logic             s2_full_q;
    logic [WIDTH:0]   sum_q;
    logic             mismatch_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic             s2_advance;
    logic             s1_load;

    assign s2_advance = !s2_full_q | out_ready_i;
    assign in_ready_o = !rst_i & (!s1_full_q | s2_advance);
    assign s1_load    = in_valid_i & in_ready_o;

    // Per-segment carry-in: ripple in exact mode, top-LOOK-bit lookahead otherwise.
    logic [NSEG-1:0]  cin_w;
    logic [NSEG-1:0]  cout_w;
    logic [WIDTH-1:0] seg_sum_w;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [BLOCK:0] seg_full;

        if (k == 0) begin : g_first
            assign cin_w[k] = 1'b0;
        end else begin : g_upper
            logic [LOOK:0] look_sum;
            assign look_sum = {1'b0, a_q[k*BLOCK-LOOK +: LOOK]}
                            + {1'b0, b_q[k*BLOCK-LOOK +: LOOK]};
            assign cin_w[k] = approx_q ? look_sum[LOOK] : cout_w[k-1];
        end

        assign seg_full = {1'b0, a_q[k*BLOCK +: BLOCK]}
                        + {1'b0, b_q[k*BLOCK +: BLOCK]}
                        + {{BLOCK{1'b0}}, cin_w[k]};
        assign cout_w[k] = seg_full[BLOCK];
        assign seg_sum_w[k*BLOCK +: BLOCK] = seg_full[BLOCK-1:0];
    end

    logic [WIDTH:0] approx_sum_w;
    logic [WIDTH:0] exact_sum_w;

    assign approx_sum_w = {cout_w[NSEG-1], seg_sum_w};
    assign exact_sum_w  = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr_i) begin
            err_cnt_d = '0;
        end else if (s2_full_q && out_ready_i && mismatch_q && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Operand registers carry no reset; they are qualified by s1_full_q.
    always_ff @(posedge clk_i) begin
        if (s1_load) begin
            a_q      <= a_i;
            b_q      <= b_i;
            approx_q <= approx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_full_q  <= 1'b0;
            s2_full_q  <= 1'b0;
            sum_q      <= '0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (in_ready_o) begin
                s1_full_q <= in_valid_i;
            end
            if (s2_advance) begin
                s2_full_q <= s1_full_q;
                if (s1_full_q) begin
                    sum_q      <= approx_sum_w;
                    mismatch_q <= (approx_sum_w != exact_sum_w);
                end
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid_o = s2_full_q;
    assign sum_o       = sum_q;
    assign mismatch_o  = mismatch_q;
    assign err_cnt_o   = err_cnt_q;
endmodule

// File: tb/tb_cda_pipe_adder.sv
// tb/tb_cda_pipe_adder.sv - directed vector bench for cda_pipe_adder
module tb_cda_pipe_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ready2;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        approx = 1'b0;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready = 1'b1;
    logic [16:0] sum;
    logic [16:0] sum2;
    logic        mismatch;
    logic        mismatch2;
    logic        err_clr = 1'b0;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;

    always #5 clk = ~clk;

    cda_pipe_adder dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .approx_i(approx), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .sum_o(sum), .mismatch_o(mismatch),
        .err_clr_i(err_clr), .err_cnt_o(err_cnt)
    );

    cda_pipe_adder #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .a_i(a), .b_i(b), .approx_i(approx), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .sum_o(sum2), .mismatch_o(mismatch2),
        .err_clr_i(err_clr), .err_cnt_o(err_cnt2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ap;
        logic [16:0] s;
        logic        mm;
    } vec_t;

    vec_t vec [8];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        a      = vec[i].a;
        b      = vec[i].b;
        approx = vec[i].ap;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_cnt16"}, 32'(err_cnt), 32'(exp_cnt));
        chk({nm, "_cnt2"}, 32'(err_cnt2), 32'((exp_cnt > 3) ? 3 : exp_cnt));
    endtask

    initial begin
        vec[0] = '{16'h00FF, 16'h0001, 1'b1, 17'h00000, 1'b1};
        vec[1] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0};
        vec[2] = '{16'h0080, 16'h0080, 1'b1, 17'h00100, 1'b0};
        vec[3] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0};
        vec[4] = '{16'hFFFF, 16'h0001, 1'b1, 17'h0FF00, 1'b1};
        vec[5] = '{16'h1234, 16'h4321, 1'b1, 17'h05555, 1'b0};
        vec[6] = '{16'h08F0, 16'h0810, 1'b1, 17'h01100, 1'b0};
        vec[7] = '{16'hFF7F, 16'h0081, 1'b1, 17'h0FF00, 1'b1};

        tick;
        tick;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk_cnt("rst");
        rst = 1'b0;
        tick;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Single beats through an idle pipeline.
        for (int i = 0; i < 8; i++) begin
            drive(i);
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 0);
            tick;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vec[i].s));
            chk($sformatf("v%0d_mismatch", i), 32'(mismatch), 32'(vec[i].mm));
            if (vec[i].mm) exp_cnt++;
            tick;
            chk($sformatf("v%0d_drained", i), 32'(out_valid), 0);
            chk_cnt($sformatf("v%0d", i));
        end

        // Back-to-back stream with out_ready pattern 1,0,0,1.
        begin
            int   sent = 0;
            int   got = 0;
            int   cyc = 0;
            logic m1 = 1'b0;
            logic m2 = 1'b0;
            logic acc, adv, n1, n2;
            logic [3:0] pat = 4'b1001;
            while (got < 8 && cyc < 80) begin
                out_ready = pat[cyc % 4];
                in_valid  = (sent < 8);
                if (sent < 8) drive(sent);
                #1;
                chk("str_in_ready", 32'(in_ready), 32'(!(m1 && m2 && !out_ready)));
                chk("str_out_valid", 32'(out_valid), 32'(m2));
                if (out_valid && out_ready) begin
                    chk($sformatf("str_sum%0d", got), 32'(sum), 32'(vec[got].s));
                    chk($sformatf("str_mm%0d", got), 32'(mismatch), 32'(vec[got].mm));
                    if (vec[got].mm) exp_cnt++;
                    got++;
                end
                acc = in_valid & in_ready;
                adv = !m2 | out_ready;
                n2  = adv ? m1 : m2;
                n1  = (!m1 | adv) ? acc : m1;
                m1  = n1;
                m2  = n2;
                if (acc) sent++;
                tick;
                cyc++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("str_all_delivered", 32'(got), 8);
            tick;
            chk("str_no_extra", 32'(out_valid), 0);
            chk_cnt("str");
        end

        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        exp_cnt = 0;
        chk_cnt("clr");

        // Five mismatching deliveries: wide counter 5, 2-bit counter saturates at 3.
        drive(0);
        in_valid = 1'b1;
        repeat (5) tick;
        in_valid = 1'b0;
        repeat (3) tick;
        exp_cnt = 5;
        chk_cnt("sat");

        // Reset with two beats held in a stalled pipeline.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(1);
        tick;
        drive(2);
        tick;
        in_valid = 1'b0;
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_sum", 32'(sum), 32'(vec[1].s));
        rst = 1'b1;
        tick;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        exp_cnt = 0;
        chk_cnt("mid_rst");
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("no_stale%0d", i), 32'(out_valid), 0);
        end
        chk("after_rst_in_ready", 32'(in_ready), 1);

        // err_clr on the same edge as a mismatching delivery.
        drive(0);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        exp_cnt = 1;
        chk_cnt("pre_clr");
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk("coinc_valid", 32'(out_valid), 1);
        chk("coinc_mm", 32'(mismatch), 1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        exp_cnt = 0;
        chk_cnt("coinc_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
